// File: rtl/add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_pkg
// Description : Shared definitions for the sliced sequential adder:
//               controller state encoding and slice-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package add_seq_pkg;

    // Controller state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Width of the slice index register: clog2(K), never narrower than 1 bit
    function automatic int idx_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_slice.sv
`default_nettype none
// ============================================================================
// Module      : add_slice
// Description : Combinational N-bit adder slice with carry in/out. The
//               sequencing controller reuses one instance for every slice.
// Revision    : 1.0 - initial release
// ============================================================================
module add_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] w_full;

    // N+1-bit sum so the carry falls out as the top bit
    always_comb begin
        w_full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        s      = w_full[N-1:0];
        cout   = w_full[N];
    end

endmodule
`default_nettype wire

// File: rtl/add_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_ctrl
// Description : Wide W=N*K bit adder built by stepping one N-bit slice over
//               K cycles. Captures operands on start, ripples the carry
//               between slices through a register and pulses done when the
//               full sum and carry-out are available.
// Revision    : 1.0 - initial release
// ============================================================================
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*K-1:0]   a,
    input  logic [N*K-1:0]   b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [N*K-1:0]   s,
    output logic             cout
);

    localparam int                W      = N * K;
    localparam int                c_IW   = idx_width(K);
    localparam logic [c_IW-1:0]   c_LAST = c_IW'(K - 1);
    localparam logic [c_IW-1:0]   c_ONE  = c_IW'(1);

    logic [1:0]      r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [c_IW-1:0] r_idx;
    logic [W-1:0]    r_s;
    logic            r_cout;
    logic            r_done;
    logic            r_busy;

    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_a_sl;
    logic [N-1:0]    w_b_sl;
    logic [N-1:0]    w_sum;
    logic            w_c;

    // Accept a new request only when idle or in the done cycle (back-to-back)
    always_comb begin
        w_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
        w_last   = (r_idx == c_LAST);
        w_a_sl   = r_a[r_idx*N +: N];
        w_b_sl   = r_b[r_idx*N +: N];
    end

    add_slice #(
        .N    (N)
    ) u_slice (
        .a    (w_a_sl),
        .b    (w_b_sl),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_c)
    );

    // Control FSM: IDLE -> RUN for K slice cycles -> DONE for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= c_ST_RUN;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (w_last) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_ONE;
                    end
                end
                c_ST_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= c_ST_RUN;
                        r_idx   <= '0;
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_idx   <= '0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operand capture, in-place slice write-back and carry chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            // Live inputs are only sampled here, so later changes cannot leak in
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
        end else if (r_state == c_ST_RUN) begin
            r_s[r_idx*N +: N] <= w_sum;
            r_carry           <= w_c;
            if (w_last) begin
                r_cout <= w_c;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Sequencing controller that performs a wide W-bit addition by time-multiplexing one narrow N-bit adder slice over K consecutive cycles, carrying between slices. It sits in front of the full-adder datapath and owns operand capture, slice selection, inter-slice carry storage and the start/done handshake. Wide adds therefore cost one small slice plus K cycles of latency instead of a full W-bit carry chain.

## Interface
- N, default 4: slice width in bits (≥1).
- K, default 8: number of slices per operation (≥1); W = N*K is derived, not a parameter.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only when the block is idle or done.
- a  input  W  operand A, captured on the accepting edge.
- b  input  W  operand B, captured on the accepting edge.
- cin  input  1  carry-in to slice 0, captured with a/b.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse: s/cout are valid.
- s  output  W  sum (a+b+cin) mod 2^W; held until the next accepted start or rst.
- cout  output  1  carry out of bit W-1; held with s.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture a, b, cin into operand/carry registers, idx←0, go to RUN; start=0 → stay.
- RUN: each edge adds slice idx: {c, s[idx*N +: N]} = a_r[idx*N +: N] + b_r[idx*N +: N] + carry_r; carry_r←c; idx←idx+1. On idx==K-1: cout←c, done←1, go to DONE.
- DONE: done=1 for exactly this cycle. start=1 → capture new operands, go to RUN (back-to-back); else go to IDLE.
- start is ignored in RUN; live a/b/cin changes after capture never affect the result.
- s slices are written in place as idx advances. s is only defined when done=1 or in IDLE after a completed op.
- Width rule: slice add is N+1 bits; no bits beyond W are kept except cout.

## Timing
- Reset values: state=IDLE, busy=0, done=0, s=0, cout=0, idx=0, carry_r=0.
- Capture edge E: RUN from E; slices processed on edges E+1..E+K; done=1 in the cycle after edge E+K.
- Latency start-to-done: K cycles after the capture edge. Throughput with back-to-back starts: one op per K+1 cycles.
- K=1: a single RUN cycle, then DONE.
- rst during RUN or DONE: abort on that edge, all outputs take reset values, no done pulse. start coincident with rst is ignored.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package add_seq_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the idx-width function (clog2(K), minimum 1).
- Sub-module add_slice: combinational N-bit adder (a, b, cin → s, cout). It is instantiated once; the controller muxes its inputs by idx.

## Test plan
All scenarios use N=4, K=8.
- Reset: hold rst 3 cycles with start=1 and random a/b → busy=0, done=0, s=0, cout=0 throughout.
- Carry ripple across all slices: a=32'h0000_0001, b=32'hFFFF_FFFF, cin=0 → done exactly 8 cycles after capture, s=32'h0000_0000, cout=1.
- Carry-in: a=32'h1234_5678, b=32'h1111_1111, cin=1 → s=32'h2345_678A, cout=0.
- Operand isolation: after capture, increment a and b every cycle and hold start=1 during RUN → result equals the sum of the captured values, and no extra operation starts before DONE.
- Reset mid-operation: rst asserted on RUN cycle 3 → next cycle IDLE, all outputs 0, no done pulse. A following op completes normally.
- Back-to-back: start=1 in the DONE cycle with new operands → second op captured there, done pulses once per op, 9 cycles apart, and each s/cout is correct.
